mem_wr_monitor: RTL and testbench

- Synthesizable end-of-test monitor that snoops the CPU data-memory write bus (mem_wr_en/mem_op/mem_addr/mem_data_in) alongside data_memory.
- Replaces fixed-delay run-then-peek benches with:
  - a tohost-style completion mailbox,
  - N parametrised byte-check channels,
  - a cycle timeout,
  - latched pass/fail status.
- Sits in every program-level bench; also usable on FPGA for status LEDs.

---
 rtl/control_types_pkg.sv | 11 +
 rtl/monitor_pkg.sv | 23 ++
 rtl/mon_check_channel.sv | 37 +++
 rtl/mem_wr_monitor.sv | 87 ++++++++
 tb/tb_mem_wr_monitor.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_types_pkg.sv
// Shared CPU control encodings; only the memory-op field is needed by the write monitor.
package control_types_pkg;

   typedef enum logic [1:0] {
      MEM_OP_NONE = 2'd0,
      MEM_OP_B    = 2'd1,
      MEM_OP_H    = 2'd2,
      MEM_OP_W    = 2'd3
   } mem_op_t;

endpackage

// File: rtl/monitor_pkg.sv
// Types and helpers for the end-of-test memory write monitor.
package monitor_pkg;
   import control_types_pkg::*;

   typedef enum logic [1:0] {
      MON_RUN     = 2'd0,
      MON_PASS    = 2'd1,
      MON_FAIL    = 2'd2,
      MON_TIMEOUT = 2'd3
   } mon_state_t;

   localparam logic [31:0] TOHOST_PASS_VAL = 32'd1;

   function automatic logic [2:0] store_bytes(input mem_op_t op);
      case (op)
         MEM_OP_B: store_bytes = 3'd1;
         MEM_OP_H: store_bytes = 3'd2;
         MEM_OP_W: store_bytes = 3'd4;
         default:  store_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mon_check_channel.sv
// One byte-check channel: remembers the last byte stored to a watched address.
module mon_check_channel (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic        wr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic [2:0]  size,
   input  logic [31:0] watch_addr,
   input  logic [7:0]  expected,
   output logic        seen,
   output logic        match
);

   logic [31:0] offset;
   logic        hit;
   logic [7:0]  lane_byte;
   logic [7:0]  captured;

   // Unsigned difference covers mem_addr <= watch_addr < mem_addr+size in one compare.
   assign offset    = watch_addr - mem_addr;
   assign hit       = en && wr && (offset < {29'd0, size});
   assign lane_byte = mem_data[{offset[1:0], 3'b000} +: 8];
   assign match     = seen && (captured == expected);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         seen     <= 1'b0;
         captured <= 8'd0;
      end else if (hit) begin
         seen     <= 1'b1;
         captured <= lane_byte;
      end
   end

endmodule

// File: rtl/mem_wr_monitor.sv
// Snoops data-memory stores: tohost mailbox completion, byte-check channels, cycle timeout.
module mem_wr_monitor
   import control_types_pkg::*;
   import monitor_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR    = 32'h0000_03FC,
   parameter int          N_CHECKS       = 4,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     mem_wr_en,
   input  mem_op_t                  mem_op,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_data_in,
   input  logic [N_CHECKS-1:0]      check_en,
   input  logic [N_CHECKS-1:0][31:0] check_addr,
   input  logic [N_CHECKS-1:0][7:0] check_exp,
   output mon_state_t               state,
   output logic                     done,
   output logic                     pass,
   output logic [31:0]              fail_code,
   output logic [N_CHECKS-1:0]      mismatch_mask,
   output logic [CNT_W-1:0]         cycle_count
);

   logic                tohost_hit;
   logic                chan_wr;
   logic [2:0]          size;
   logic [N_CHECKS-1:0] ch_match;
   logic [N_CHECKS-1:0] ch_seen;
   logic [N_CHECKS-1:0] mism;

   assign size       = store_bytes(mem_op);
   assign tohost_hit = (state == MON_RUN) && mem_wr_en && (mem_op == MEM_OP_W) &&
                       (mem_addr == TOHOST_ADDR);
   // The mailbox store itself and anything after termination never reach the channels.
   assign chan_wr    = (state == MON_RUN) && mem_wr_en && !tohost_hit;
   assign mism       = check_en & ~ch_match;

   for (genvar k = 0; k < N_CHECKS; k++) begin : g_chan
      mon_check_channel u_chan (
         .clk        (clk),
         .resetn     (resetn),
         .en         (check_en[k]),
         .wr         (chan_wr),
         .mem_addr   (mem_addr),
         .mem_data   (mem_data_in),
         .size       (size),
         .watch_addr (check_addr[k]),
         .expected   (check_exp[k]),
         .seen       (ch_seen[k]),
         .match      (ch_match[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= MON_RUN;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail_code     <= 32'd0;
         mismatch_mask <= '0;
         cycle_count   <= '0;
      end else if (state == MON_RUN) begin
         if (tohost_hit) begin
            done          <= 1'b1;
            mismatch_mask <= mism;
            if (mem_data_in == TOHOST_PASS_VAL && mism == '0) begin
               state <= MON_PASS;
               pass  <= 1'b1;
            end else begin
               state     <= MON_FAIL;
               fail_code <= (mem_data_in == TOHOST_PASS_VAL) ? 32'd0 : (mem_data_in >> 1);
            end
         end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= MON_TIMEOUT;
            done          <= 1'b1;
            mismatch_mask <= mism;
         end else begin
            cycle_count <= cycle_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_wr_monitor.sv
// Bench for mem_wr_monitor: vector table of single-store scenarios plus timeout/mailbox sequences.
module tb_mem_wr_monitor;
   import control_types_pkg::*;
   import monitor_pkg::*;

   localparam int N = 4;
   localparam int TO = 1000;
   localparam int CW = $clog2(TO + 1);
   localparam logic [31:0] TH = 32'h0000_03FC;
   localparam int PW = 2 + 1 + 1 + N + 32;

   logic                clk = 1'b0;
   logic                resetn;
   logic                mem_wr_en;
   mem_op_t             mem_op;
   logic [31:0]         mem_addr;
   logic [31:0]         mem_data_in;
   logic [N-1:0]        check_en;
   logic [N-1:0][31:0]  check_addr;
   logic [N-1:0][7:0]   check_exp;
   mon_state_t          state;
   logic                done;
   logic                pass;
   logic [31:0]         fail_code;
   logic [N-1:0]        mismatch_mask;
   logic [CW-1:0]       cycle_count;

   int checks = 0;
   int errors = 0;
   logic [PW-1:0] exp_q[$];

   mem_wr_monitor #(.TOHOST_ADDR(TH), .N_CHECKS(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn), .mem_wr_en(mem_wr_en), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .check_en(check_en),
      .check_addr(check_addr), .check_exp(check_exp), .state(state), .done(done),
      .pass(pass), .fail_code(fail_code), .mismatch_mask(mismatch_mask),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st_en;
      mem_op_t     op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  ch_en;
      logic [31:0] a0;
      logic [7:0]  e0;
      logic [31:0] a1;
      logic [7:0]  e1;
      logic [31:0] th_val;
      mon_state_t  st;
      logic [N-1:0] mask;
      logic [31:0] fc;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [PW-1:0] pack_exp(mon_state_t st, logic [N-1:0] m, logic [31:0] fc);
      pack_exp = {st, st != MON_RUN, st == MON_PASS, m, fc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      mem_wr_en = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   task automatic do_store(mem_op_t op, logic [31:0] addr, logic [31:0] data);
      mem_wr_en = 1'b1;
      mem_op = op;
      mem_addr = addr;
      mem_data_in = data;
      tick();
      mem_wr_en = 1'b0;
      mem_op = MEM_OP_NONE;
   endtask

   task automatic check_val(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic check_pop(string name);
      logic [PW-1:0] e;
      logic [PW-1:0] a;
      checks++;
      a = {state, done, pass, mismatch_mask, fail_code};
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got %0h", name, a);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got {st,done,pass,mask,fc}=%0h expected %0h", name, a, e);
         end
      end
   endtask

   task automatic set_checks(logic [1:0] en, logic [31:0] a0, logic [7:0] e0,
                             logic [31:0] a1, logic [7:0] e1);
      check_en = {2'b00, en};
      check_addr = '0;
      check_exp = '0;
      check_addr[0] = a0;
      check_exp[0] = e0;
      check_addr[1] = a1;
      check_exp[1] = e1;
   endtask

   initial begin
      mem_wr_en = 1'b0;
      mem_op = MEM_OP_NONE;
      mem_addr = '0;
      mem_data_in = '0;
      check_en = '0;
      check_addr = '0;
      check_exp = '0;
      resetn = 1'b0;

      vecs[0] = '{1'b1, MEM_OP_B, 32'h200, 32'h0000_000a, 2'b01, 32'h200, 8'h0a, 32'h0, 8'h00,
                  32'd1, MON_PASS, 4'b0000, 32'd0};
      vecs[1] = '{1'b1, MEM_OP_W, 32'h200, 32'h1122_3344, 2'b11, 32'h201, 8'h33, 32'h203, 8'h12,
                  32'd1, MON_FAIL, 4'b0010, 32'd0};
      vecs[2] = '{1'b0, MEM_OP_NONE, 32'h0, 32'h0, 2'b10, 32'h0, 8'h00, 32'h300, 8'h55,
                  32'd1, MON_FAIL, 4'b0010, 32'd0};
      vecs[3] = '{1'b0, MEM_OP_NONE, 32'h0, 32'h0, 2'b10, 32'h0, 8'h00, 32'h300, 8'h55,
                  32'd7, MON_FAIL, 4'b0010, 32'd3};
      vecs[4] = '{1'b1, MEM_OP_H, 32'h202, 32'h0000_beef, 2'b11, 32'h203, 8'hbe, 32'h202, 8'hef,
                  32'd1, MON_PASS, 4'b0000, 32'd0};
      vecs[5] = '{1'b1, MEM_OP_H, 32'h202, 32'h0000_beef, 2'b11, 32'h203, 8'hbe, 32'h204, 8'h00,
                  32'd0, MON_FAIL, 4'b0010, 32'd0};
      vecs[6] = '{1'b1, MEM_OP_B, 32'h201, 32'h0000_0077, 2'b01, 32'h200, 8'h00, 32'h0, 8'h00,
                  32'd1, MON_FAIL, 4'b0001, 32'd0};
      vecs[7] = '{1'b0, MEM_OP_NONE, 32'h0, 32'h0, 2'b00, 32'h0, 8'h00, 32'h0, 8'h00,
                  32'h8000_0001, MON_FAIL, 4'b0000, 32'h4000_0000};

      // Reset and idle counting
      do_reset();
      tick(); tick(); tick();
      check_val("idle_state", 32'(state), 32'(MON_RUN));
      check_val("idle_done", 32'(done), 32'd0);
      check_val("idle_count", 32'(cycle_count), 32'd3);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check_val("midrun_reset_count", 32'(cycle_count), 32'd0);
      exp_q.push_back(pack_exp(MON_RUN, '0, 32'd0));
      check_pop("reset_outputs");

      foreach (vecs[i]) begin
         set_checks(vecs[i].ch_en, vecs[i].a0, vecs[i].e0, vecs[i].a1, vecs[i].e1);
         do_reset();
         if (vecs[i].st_en) do_store(vecs[i].op, vecs[i].addr, vecs[i].data);
         exp_q.push_back(pack_exp(vecs[i].st, vecs[i].mask, vecs[i].fc));
         do_store(MEM_OP_W, TH, vecs[i].th_val);
         check_pop($sformatf("vec%0d", i));
      end

      // Last write wins, then terminal state ignores later mailbox stores
      set_checks(2'b01, 32'h200, 8'h0a, 32'h0, 8'h00);
      do_reset();
      do_store(MEM_OP_B, 32'h200, 32'h0000_0001);
      do_store(MEM_OP_B, 32'h200, 32'h0000_000a);
      exp_q.push_back(pack_exp(MON_PASS, 4'b0000, 32'd0));
      do_store(MEM_OP_W, TH, 32'd1);
      check_pop("last_write_wins");
      exp_q.push_back(pack_exp(MON_PASS, 4'b0000, 32'd0));
      do_store(MEM_OP_W, TH, 32'd7);
      check_pop("terminal_absorbs");

      // Timeout with an enabled channel never written
      set_checks(2'b01, 32'h100, 8'h00, 32'h0, 8'h00);
      do_reset();
      for (int c = 0; c < TO - 1; c++) tick();
      check_val("pre_timeout_state", 32'(state), 32'(MON_RUN));
      check_val("pre_timeout_count", 32'(cycle_count), 32'(TO - 1));
      exp_q.push_back(pack_exp(MON_TIMEOUT, 4'b0001, 32'd0));
      tick();
      check_pop("timeout");
      check_val("timeout_count", 32'(cycle_count), 32'(TO - 1));
      exp_q.push_back(pack_exp(MON_TIMEOUT, 4'b0001, 32'd0));
      do_store(MEM_OP_W, TH, 32'd1);
      check_pop("tohost_after_timeout");
      check_val("timeout_count_frozen", 32'(cycle_count), 32'(TO - 1));

      // Mailbox store in the expiry cycle wins over timeout
      set_checks(2'b00, 32'h0, 8'h00, 32'h0, 8'h00);
      do_reset();
      for (int c = 0; c < TO - 1; c++) tick();
      exp_q.push_back(pack_exp(MON_PASS, 4'b0000, 32'd0));
      do_store(MEM_OP_W, TH, 32'd1);
      check_pop("expiry_tohost_wins");
      check_val("expiry_count", 32'(cycle_count), 32'(TO - 1));

      // Byte store to the mailbox feeds channels but does not complete
      set_checks(2'b01, TH, 8'h02, 32'h0, 8'h00);
      do_reset();
      exp_q.push_back(pack_exp(MON_RUN, 4'b0000, 32'd0));
      do_store(MEM_OP_B, TH, 32'h0000_0002);
      check_pop("sb_tohost_no_complete");
      exp_q.push_back(pack_exp(MON_PASS, 4'b0000, 32'd0));
      do_store(MEM_OP_W, TH, 32'd1);
      check_pop("tohost_sw_not_captured");

      // Reset from a terminal state returns to RUN
      do_reset();
      exp_q.push_back(pack_exp(MON_RUN, '0, 32'd0));
      check_pop("reset_from_terminal");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
